// File: rtl/irq_controller.sv
// Four-source prioritised interrupt controller with a memory-mapped register window.
// Define IRQ_CTRL_EOI_EN to hold SERVICE until an EOI write; otherwise SERVICE lasts one cycle.
module irq_controller #(
    parameter logic [7:0] BASE_ADDR  = 8'hE0,
    parameter logic [3:0] MASK_RESET = 4'hF
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [3:0] SRC_RAISE,
    output logic [3:0] SRC_ACK,
    output logic       CPU_RAISE,
    input  logic       CPU_ACK
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRaise   = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] id_q, id_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] src_q, src_prev_q;
    logic [3:0] src_ack_q, src_ack_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rd_valid_q;

    logic [7:0] offset;
    logic       owned, wr_en, rd_en;
    logic       mask_wr, pend_wr;
    logic [3:0] rise, w1c, ack_clr, masked, id_onehot;
    logic [1:0] lowest;
    logic       unused_wdata;

    // Wrapping subtraction lets the window sit anywhere in the address space.
    assign offset    = BUS_ADDR - BASE_ADDR;
    assign owned     = (offset[7:2] == 6'd0);
    assign wr_en     = BUS_WE & owned;
    assign rd_en     = ~BUS_WE & owned;
    assign mask_wr   = wr_en && (offset[1:0] == 2'd0);
    assign pend_wr   = wr_en && (offset[1:0] == 2'd1);

`ifdef IRQ_CTRL_EOI_EN
    logic eoi_wr;
    assign eoi_wr    = wr_en && (offset[1:0] == 2'd3);
`endif

    assign unused_wdata = ^BUS_DATA[7:4];

    assign rise      = src_q & ~src_prev_q;
    assign w1c       = pend_wr ? BUS_DATA[3:0] : 4'b0000;
    assign id_onehot = 4'b0001 << id_q;
    assign ack_clr   = ((state_q == StRaise) && CPU_ACK) ? id_onehot : 4'b0000;
    assign masked    = pending_q & mask_q;

    // A fresh edge is OR-ed in last so it survives a same-cycle clear.
    assign pending_d = (pending_q & ~w1c & ~ack_clr) | rise;
    assign mask_d    = mask_wr ? BUS_DATA[3:0] : mask_q;

    always_comb begin
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (masked[i]) lowest = i[1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        src_ack_d = 4'b0000;
        case (state_q)
            StIdle: begin
                if (masked != 4'b0000) begin
                    id_d    = lowest;
                    state_d = StRaise;
                end
            end
            StRaise: begin
                if (CPU_ACK) begin
                    src_ack_d = id_onehot;
                    state_d   = StService;
                end
            end
            StService: begin
`ifdef IRQ_CTRL_EOI_EN
                if (eoi_wr) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = 8'h00;
        case (offset[1:0])
            2'd0:    rdata_d = {4'b0000, mask_q};
            2'd1:    rdata_d = {4'b0000, pending_q};
            2'd2:    rdata_d = {(state_q == StService), 5'b00000, id_q};
            default: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            id_q       <= 2'd0;
            mask_q     <= MASK_RESET;
            pending_q  <= 4'b0000;
            src_q      <= 4'b0000;
            src_prev_q <= 4'b0000;
            src_ack_q  <= 4'b0000;
            rdata_q    <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            src_q      <= SRC_RAISE;
            src_prev_q <= src_q;
            src_ack_q  <= src_ack_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_en;
        end
    end

    assign BUS_DATA  = rd_valid_q ? rdata_q : 8'hzz;
    assign SRC_ACK   = src_ack_q;
    assign CPU_RAISE = (state_q == StRaise);

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hE0: bus address of register 0; the block owns BASE_ADDR..BASE_ADDR+3.
REQ-002 SHALL have parameter MASK_RESET, default 4'hF: reset value of the MASK register (1 = source enabled).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; every flop is rising-edge CLK.
REQ-004 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port BUS_DATA, inout, 8 bits: shared data bus, driven only during an owned read.
REQ-006 SHALL have port BUS_ADDR, input, 8 bits: shared address bus.
REQ-007 SHALL have port BUS_WE, input, 1 bit: bus write enable.
REQ-008 SHALL have port SRC_RAISE, input, 4 bits: peripheral interrupt requests; bit 0 is highest priority.
REQ-009 SHALL have port SRC_ACK, output, 4 bits: one-cycle acknowledge pulse per source.
REQ-010 SHALL have port CPU_RAISE, output, 1 bit: interrupt request to the processor.
REQ-011 SHALL have port CPU_ACK, input, 1 bit: processor acknowledge.

Function
REQ-012 SHALL register SRC_RAISE and set PENDING[i] on each 0->1 transition of SRC_RAISE[i].
REQ-013 SHALL use this register map: +0 MASK (R/W, bits 3:0); +1 PENDING (R; write 1 clears a bit); +2 VECTOR (R: bit 7 = in service, bits 1:0 = active id, other bits 0); +3 EOI (W: any write ends service).
REQ-014 SHALL drive BUS_DATA with registered read data in the cycle after BUS_WE=0 presents an owned address, and SHALL hold BUS_DATA high-Z at all other times; unused register bits read 0.
REQ-015 SHALL update registers on the cycle BUS_WE=1 presents an owned address; writes to other addresses SHALL have no effect.
REQ-016 SHALL implement the FSM IDLE -> RAISE -> SERVICE -> IDLE.
REQ-017 IDLE: if (PENDING & MASK) != 0, SHALL latch the lowest set index as the active id and enter RAISE on the next cycle.
REQ-018 RAISE: SHALL hold CPU_RAISE=1 until CPU_ACK=1 is sampled.
REQ-019 On sampling CPU_ACK in RAISE, SHALL in the next cycle drop CPU_RAISE, pulse SRC_ACK[id] for exactly 1 cycle, clear PENDING[id] and enter SERVICE.
REQ-020 SHALL ignore CPU_ACK outside RAISE.
REQ-021 A new edge on a source SHALL win over an ack-clear or W1C of the same PENDING bit in the same cycle; no event SHALL be lost.
REQ-022 A masked source SHALL stay pending and SHALL be dispatched once unmasked.
REQ-023 Clearing MASK[id] while in RAISE SHALL NOT withdraw CPU_RAISE.
REQ-024 SHALL allow at most one interrupt in service; no nesting or preemption.
REQ-025 Minimum latency from a SRC_RAISE edge to CPU_RAISE=1 SHALL be 3 cycles (sync, pending, dispatch).

Reset
REQ-026 While RESET=1 at a clock edge, SHALL set: FSM=IDLE, PENDING=0, MASK=MASK_RESET, CPU_RAISE=0, SRC_ACK=0, VECTOR=0, edge registers=0, BUS_DATA high-Z.
REQ-027 Reset asserted in RAISE or SERVICE SHALL abort service with no SRC_ACK pulse.

Configuration
REQ-028 With macro IRQ_CTRL_EOI_EN defined: SERVICE SHALL remain until an EOI write, then return to IDLE, and VECTOR bit 7 SHALL stay 1 throughout SERVICE.
REQ-029 With IRQ_CTRL_EOI_EN undefined: SERVICE SHALL last one cycle then return to IDLE, EOI writes SHALL be ignored, and VECTOR bit 7 SHALL be 1 only in SERVICE.

Verification
REQ-030 Raise SRC_RAISE[2] with MASK=F -> CPU_RAISE=1 3 cycles later; after CPU_ACK, SRC_ACK=4'b0100 for 1 cycle and PENDING reads 0.
REQ-031 Raise SRC_RAISE[3] and SRC_RAISE[1] in the same cycle -> id 1 dispatched first; id 3 dispatched after service ends (after the EOI write when IRQ_CTRL_EOI_EN is defined).
REQ-032 Write MASK=4'h0, then raise SRC_RAISE[0] -> no CPU_RAISE and PENDING=8'h01; write MASK=4'h1 -> CPU_RAISE rises.
REQ-033 Write 8'h01 to BASE+1 in the same cycle as a new SRC_RAISE[0] edge -> PENDING bit 0 remains 1.
REQ-034 Assert RESET during RAISE -> next cycle CPU_RAISE=0, MASK reads 8'h0F, no SRC_ACK pulse; read BASE+2 -> 8'h00 one cycle after the address, with BUS_DATA high-Z otherwise.
